// File: rtl/li_seq_gen_pkg.sv
// Shared definitions for the constant-materialisation sequencer: request modes,
// FSM states, RV64I opcode/funct3 constants and request classification.
package li_seq_gen_pkg;

    typedef enum logic [1:0] {
        M0,
        M12,
        M32,
        M64
    } li_mode_e;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } li_state_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;

    // Shortest sequence class for the request; rd == x0 always collapses to a nop.
    function automatic li_mode_e classify(input logic [4:0] rd, input logic [63:0] imm);
        li_mode_e m;
        if (rd == '0) begin
            m = M0;
        end else if (imm == {{52{imm[11]}}, imm[11:0]}) begin
            m = M12;
        end else if (imm == {{32{imm[31]}}, imm[31:0]}) begin
            m = M32;
        end else begin
            m = M64;
        end
        return m;
    endfunction

endpackage

// File: rtl/li_word_enc.sv
// Combinational encoder: maps (mode, step, rd, imm) to one raw RV64I word, its
// last-word flag and the following step index.
module li_word_enc
    import li_seq_gen_pkg::*;
(
    input  li_mode_e    mode,
    input  logic [2:0]  step,
    input  logic [4:0]  rd,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        last,
    output logic [2:0]  step_next
);

    logic [31:0] v;
    logic [31:0] v_rnd;
    logic        fits12;
    logic        two_word;
    logic [31:0] w_addi0;
    logic [31:0] w_lui;
    logic [31:0] w_addiw;
    logic [31:0] w_mat;

    // Steps 0/1 are the 32-bit materialisation (step 1 = addiw, possibly skipped);
    // steps 2..7 are the shift/add chunks of the 64-bit tail.
    always_comb begin
        v        = (mode == M64) ? imm[63:32] : imm[31:0];
        v_rnd    = v + 32'h0000_0800;
        fits12   = (v == {{20{v[11]}}, v[11:0]});
        two_word = !fits12 && (v[11:0] != '0);
        w_addi0  = {v[11:0], 5'd0, F3_ADD, rd, OP_IMM};
        w_lui    = {v_rnd[31:12], rd, OP_LUI};
        w_addiw  = {v[11:0], rd, F3_ADD, rd, OP_IMM32};
        if (step == 3'd0) begin
            w_mat = fits12 ? w_addi0 : w_lui;
        end else begin
            w_mat = w_addiw;
        end
    end

    always_comb begin
        instr     = '0;
        last      = 1'b0;
        step_next = step + 3'd1;
        case (mode)
            M0: begin
                instr = {12'd0, 5'd0, F3_ADD, 5'd0, OP_IMM};
                last  = 1'b1;
            end
            M12: begin
                instr = w_addi0;
                last  = 1'b1;
            end
            M32: begin
                instr = w_mat;
                last  = (step == {2'b00, two_word});
            end
            M64: begin
                if (step == 3'd0 && !two_word) begin
                    step_next = 3'd2;
                end
                last = (step == 3'd7);
                case (step)
                    3'd0, 3'd1: instr = w_mat;
                    3'd2:       instr = {6'd0, 6'd11, rd, F3_SLL, rd, OP_IMM};
                    3'd3:       instr = {1'b0, imm[31:21], rd, F3_ADD, rd, OP_IMM};
                    3'd4:       instr = {6'd0, 6'd11, rd, F3_SLL, rd, OP_IMM};
                    3'd5:       instr = {1'b0, imm[20:10], rd, F3_ADD, rd, OP_IMM};
                    3'd6:       instr = {6'd0, 6'd10, rd, F3_SLL, rd, OP_IMM};
                    default:    instr = {2'b00, imm[9:0], rd, F3_ADD, rd, OP_IMM};
                endcase
            end
            default: begin
                instr = '0;
                last  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/li_seq_gen.sv
// Constant-materialisation sequencer: accepts (rd, imm) and emits, one per output
// handshake, the addi/lui/addiw/slli words that load imm into rd.
module li_seq_gen
    import li_seq_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [63:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        busy
);

    li_state_e   state_q, state_d;
    li_mode_e    mode_q, mode_d;
    logic [2:0]  step_q, step_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] imm_q, imm_d;

    logic [31:0] enc_instr;
    logic        enc_last;
    logic [2:0]  enc_step_next;

    li_word_enc u_enc (
        .mode      (mode_q),
        .step      (step_q),
        .rd        (rd_q),
        .imm       (imm_q),
        .instr     (enc_instr),
        .last      (enc_last),
        .step_next (enc_step_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= M0;
            step_q  <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mode_d  = classify(req_rd, req_imm);
                    rd_d    = req_rd;
                    imm_d   = req_imm;
                    step_d  = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (enc_last) begin
                        step_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        step_d = enc_step_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q == S_EMIT);
        out_valid = busy;
        out_instr = busy ? enc_instr : '0;
        out_last  = busy & enc_last;
    end

endmodule

// File: tb/tb_li_seq_gen.sv
// Directed + randomized bench for li_seq_gen against an arithmetic model of the
// instruction sequence for each requested constant.
module tb_li_seq_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [63:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    li_seq_gen dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [11:0] k, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {k, rs1, f3, rd, op};
    endfunction

    task automatic mat32(input logic [4:0] rd, input logic [31:0] v);
        int signed   sv;
        logic [31:0] hi;
        sv = $signed(v);
        if (sv >= -2048 && sv <= 2047) begin
            exp_q.push_back(itype(v[11:0], 5'd0, 3'd0, rd, 7'h13));
        end else begin
            hi = (v + 32'h800) >> 12;
            exp_q.push_back({hi[19:0], rd, 7'h37});
            if (v % 4096 != 0) exp_q.push_back(itype(v[11:0], rd, 3'd0, rd, 7'h1B));
        end
    endtask

    task automatic model(input logic [4:0] rd, input logic [63:0] imm);
        longint signed s;
        logic [63:0]   c;
        s = $signed(imm);
        exp_q.delete();
        if (rd == 5'd0) begin
            exp_q.push_back(32'h0000_0013);
        end else if (s >= -2048 && s <= 2047) begin
            exp_q.push_back(itype(imm[11:0], 5'd0, 3'd0, rd, 7'h13));
        end else if (s >= -64'sd2147483648 && s <= 64'sd2147483647) begin
            mat32(rd, imm[31:0]);
        end else begin
            mat32(rd, imm[63:32]);
            c = (imm >> 21) & 64'h7FF;
            exp_q.push_back(itype(12'd11, rd, 3'd1, rd, 7'h13));
            exp_q.push_back(itype(c[11:0], rd, 3'd0, rd, 7'h13));
            c = (imm >> 10) & 64'h7FF;
            exp_q.push_back(itype(12'd11, rd, 3'd1, rd, 7'h13));
            exp_q.push_back(itype(c[11:0], rd, 3'd0, rd, 7'h13));
            c = imm & 64'h3FF;
            exp_q.push_back(itype(12'd10, rd, 3'd1, rd, 7'h13));
            exp_q.push_back(itype(c[11:0], rd, 3'd0, rd, 7'h13));
        end
    endtask

    // Issues one request and follows the sequence; n_take < 0 consumes it all.
    task automatic run_seq(input logic [4:0] rd, input logic [63:0] imm, input int stall_at,
                           input int stall_len, input bit rnd, input bit poke, input int n_take);
        int idx;
        int held;
        int cyc;
        int lim;
        bit rdy;
        model(rd, imm);
        lim = (n_take < 0) ? exp_q.size() : n_take;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_rd    = rd;
        req_imm   = imm;
        tick();
        req_valid = poke;
        req_rd    = ~rd;
        req_imm   = ~imm;
        idx = 0;
        held = 0;
        cyc = 0;
        while (idx < lim && cyc < 200) begin
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("busy", {63'd0, busy}, 64'd1);
            chk("req_ready_emit", {63'd0, req_ready}, 64'd0);
            chk("out_instr", {32'd0, out_instr}, {32'd0, exp_q[idx]});
            chk("out_last", {63'd0, out_last}, (idx == exp_q.size() - 1) ? 64'd1 : 64'd0);
            rdy = 1'b1;
            if (idx == stall_at && held < stall_len) begin
                rdy = 1'b0;
                held++;
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                rdy = 1'b0;
            end
            out_ready = rdy;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        chk("words_consumed", 64'(idx), 64'(lim));
        if (n_take < 0) begin
            chk("out_valid_after", {63'd0, out_valid}, 64'd0);
            chk("req_ready_after", {63'd0, req_ready}, 64'd1);
        end
    endtask

    logic [63:0] edges [8];
    logic [63:0] rimm;
    logic [4:0]  rrd;
    int          kind;
    logic [31:0] r;

    initial begin
        edges[0] = 64'h0000_0000_7FFF_F800;
        edges[1] = 64'h0000_0000_7FFF_FFFF;
        edges[2] = 64'hFFFF_FFFF_8000_0000;
        edges[3] = 64'h0000_0000_8000_0000;
        edges[4] = 64'h8000_0000_0000_0000;
        edges[5] = 64'h7FFF_FFFF_FFFF_FFFF;
        edges[6] = 64'h0000_0000_0000_07FF;
        edges[7] = 64'hFFFF_FFFF_FFFF_F7FF;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_rd    = '0;
        req_imm   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        reset = 1'b1;
        tick();

        run_seq(5'd10, 64'd5, -1, 0, 1'b0, 1'b0, -1);
        chk("model_addi5", {32'd0, exp_q[0]}, 64'h0050_0513);
        run_seq(5'd10, 64'hFFFF_FFFF_FFFF_F800, -1, 0, 1'b0, 1'b0, -1);
        run_seq(5'd1, 64'h0000_0000_1234_5000, -1, 0, 1'b0, 1'b0, -1);
        run_seq(5'd1, 64'h0000_0000_1234_5FFF, -1, 0, 1'b0, 1'b0, -1);
        chk("model_lui_len", 64'(exp_q.size()), 64'd2);
        run_seq(5'd5, 64'h0000_0001_0000_0000, 2, 3, 1'b0, 1'b0, -1);
        chk("model_m64_len", 64'(exp_q.size()), 64'd7);
        run_seq(5'd0, 64'hDEAD_BEEF_1234_5678, -1, 0, 1'b0, 1'b1, -1);
        run_seq(5'd3, 64'h0000_0000_7FFF_F800, -1, 0, 1'b0, 1'b1, -1);

        run_seq(5'd5, 64'h0000_0001_0000_0000, -1, 0, 1'b0, 1'b0, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_last", {63'd0, out_last}, 64'd0);
        chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        #3;
        reset = 1'b1;
        run_seq(5'd10, 64'd5, -1, 0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            r    = $urandom;
            rrd  = 5'($urandom_range(0, 31));
            case (kind)
                0:       rimm = {{52{r[11]}}, r[11:0]};
                1:       rimm = {{32{r[31]}}, r};
                2:       rimm = {$urandom, r};
                default: rimm = edges[$urandom_range(0, 7)];
            endcase
            run_seq(rrd, rimm, -1, 0, 1'b1, i[0], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
